// File: rtl/lsu_pkg.sv
// Shared core definitions for the load/store unit: RV64 load/store funct3
// encodings, FSM states, default bus timeout and the request legality check.
package lsu_pkg;

   localparam int unsigned c_TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS,
      ST_DONE
   } state_e;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_D  = 3'b011,
      F3_BU = 3'b100,
      F3_HU = 3'b101,
      F3_WU = 3'b110
   } funct3_e;

   // funct3[1:0] is log2 of the access size for both loads and stores.
   function automatic logic isLegal(input logic       isRead,
                                    input logic       isWrite,
                                    input logic [2:0] funct3,
                                    input logic [2:0] offset);
      logic ok;
      ok = 1'b1;
      if (isRead && isWrite)            ok = 1'b0;
      if (isRead && funct3 == 3'b111)   ok = 1'b0;
      if (isWrite && funct3[2])         ok = 1'b0;
      case (funct3[1:0])
         2'b01:   if (offset[0])             ok = 1'b0;
         2'b10:   if (offset[1:0] != 2'b00)  ok = 1'b0;
         2'b11:   if (offset != 3'b000)      ok = 1'b0;
         default: ;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication, load
// lane extraction with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_Funct3,
   input  logic [2:0]  i_Offset,
   input  logic        i_IsStore,
   input  logic [63:0] i_WriteData,
   input  logic [63:0] i_MemRdata,
   output logic [7:0]  o_MemBe,
   output logic [63:0] o_MemWdata,
   output logic [63:0] o_LoadData
);

   logic [63:0] lane;

   always_comb begin
      lane       = i_MemRdata >> {i_Offset, 3'b000};
      o_LoadData = lane;
      o_MemBe    = 8'hFF;
      o_MemWdata = i_WriteData;
      case (funct3_e'(i_Funct3))
         F3_B: begin
            o_LoadData = {{56{lane[7]}}, lane[7:0]};
            o_MemBe    = 8'h01 << i_Offset;
            o_MemWdata = {8{i_WriteData[7:0]}};
         end
         F3_BU: o_LoadData = {56'd0, lane[7:0]};
         F3_H: begin
            o_LoadData = {{48{lane[15]}}, lane[15:0]};
            o_MemBe    = 8'h03 << i_Offset;
            o_MemWdata = {4{i_WriteData[15:0]}};
         end
         F3_HU: o_LoadData = {48'd0, lane[15:0]};
         F3_W: begin
            o_LoadData = {{32{lane[31]}}, lane[31:0]};
            o_MemBe    = 8'h0F << i_Offset;
            o_MemWdata = {2{i_WriteData[31:0]}};
         end
         F3_WU: o_LoadData = {32'd0, lane[31:0]};
         default: ;
      endcase
      if (!i_IsStore) o_MemBe = 8'hFF;
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one execute-stage request, runs a single bus
// transaction with timeout, and writes back extended load data.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned c_TIMEOUT = c_TIMEOUT_DEFAULT
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Valid,
   output logic        o_Ready,
   input  logic        i_MemRead,
   input  logic        i_MemWrite,
   input  logic [2:0]  i_Funct3,
   input  logic [63:0] i_Address,
   input  logic [63:0] i_WriteData,
   input  logic [4:0]  i_WriteReg,
   output logic [63:0] o_ReadData,
   output logic        o_WbValid,
   output logic [4:0]  o_WbReg,
   output logic        o_Fault,
   output logic        o_MemReq,
   input  logic        i_MemAck,
   output logic        o_MemWe,
   output logic [63:0] o_MemAddr,
   output logic [63:0] o_MemWdata,
   output logic [7:0]  o_MemBe,
   input  logic [63:0] i_MemRdata
);

   state_e      r_State;
   logic [2:0]  r_Funct3;
   logic [2:0]  r_Offset;
   logic [4:0]  r_Rd;
   logic [31:0] r_Count;

   logic        isIdle;
   logic        isLegalReq;
   logic [2:0]  alignFunct3;
   logic [2:0]  alignOffset;
   logic        alignStore;
   logic [7:0]  alignBe;
   logic [63:0] alignWdata;
   logic [63:0] alignLoad;

   assign isIdle     = (r_State == ST_IDLE);
   assign o_Ready    = isIdle;
   assign isLegalReq = isLegal(i_MemRead, i_MemWrite, i_Funct3, i_Address[2:0]);

   // One aligner serves both phases: live inputs at acceptance, the
   // registered request while waiting for the read data.
   assign alignFunct3 = isIdle ? i_Funct3       : r_Funct3;
   assign alignOffset = isIdle ? i_Address[2:0] : r_Offset;
   assign alignStore  = isIdle ? i_MemWrite     : o_MemWe;

   lsu_align u_align (
      .i_Funct3    (alignFunct3),
      .i_Offset    (alignOffset),
      .i_IsStore   (alignStore),
      .i_WriteData (i_WriteData),
      .i_MemRdata  (i_MemRdata),
      .o_MemBe     (alignBe),
      .o_MemWdata  (alignWdata),
      .o_LoadData  (alignLoad)
   );

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_State    <= ST_IDLE;
         r_Funct3   <= '0;
         r_Offset   <= '0;
         r_Rd       <= '0;
         r_Count    <= '0;
         o_MemReq   <= 1'b0;
         o_MemWe    <= 1'b0;
         o_MemAddr  <= '0;
         o_MemWdata <= '0;
         o_MemBe    <= '0;
         o_ReadData <= '0;
         o_WbValid  <= 1'b0;
         o_WbReg    <= '0;
         o_Fault    <= 1'b0;
      end else begin
         o_Fault   <= 1'b0;
         o_WbValid <= 1'b0;
         case (r_State)
            ST_IDLE: begin
               if (i_Valid && (i_MemRead || i_MemWrite)) begin
                  if (!isLegalReq) begin
                     o_Fault <= 1'b1;
                  end else begin
                     r_State    <= ST_BUS;
                     r_Funct3   <= i_Funct3;
                     r_Offset   <= i_Address[2:0];
                     r_Rd       <= i_WriteReg;
                     r_Count    <= '0;
                     o_MemReq   <= 1'b1;
                     o_MemWe    <= i_MemWrite;
                     o_MemAddr  <= {i_Address[63:3], 3'b000};
                     o_MemWdata <= alignWdata;
                     o_MemBe    <= alignBe;
                  end
               end
            end
            ST_BUS: begin
               if (i_MemAck) begin
                  o_MemReq <= 1'b0;
                  if (o_MemWe) begin
                     r_State <= ST_IDLE;
                  end else begin
                     r_State    <= ST_DONE;
                     o_ReadData <= alignLoad;
                     o_WbValid  <= (r_Rd != 5'd0);
                     o_WbReg    <= r_Rd;
                  end
               end else if (r_Count == c_TIMEOUT - 1) begin
                  r_State  <= ST_IDLE;
                  o_MemReq <= 1'b0;
                  o_Fault  <= 1'b1;
               end else begin
                  r_Count <= r_Count + 32'd1;
               end
            end
            ST_DONE: r_State <= ST_IDLE;
            default: r_State <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, multi-cycle corner
// sequences, and random requests against an arithmetic reference model.
module tb_lsu;

   localparam int unsigned c_TO = 255;

   logic        r_Clock;
   logic        i_Reset, i_Valid, i_MemRead, i_MemWrite, i_MemAck;
   logic [2:0]  i_Funct3;
   logic [63:0] i_Address, i_WriteData, i_MemRdata;
   logic [4:0]  i_WriteReg;
   logic        o_Ready, o_WbValid, o_Fault, o_MemReq, o_MemWe;
   logic [63:0] o_ReadData, o_MemAddr, o_MemWdata;
   logic [4:0]  o_WbReg;
   logic [7:0]  o_MemBe;

   int total = 0;
   int bad   = 0;

   lsu #(.c_TIMEOUT(c_TO)) dut (
      .i_Clock     (r_Clock),
      .i_Reset     (i_Reset),
      .i_Valid     (i_Valid),
      .o_Ready     (o_Ready),
      .i_MemRead   (i_MemRead),
      .i_MemWrite  (i_MemWrite),
      .i_Funct3    (i_Funct3),
      .i_Address   (i_Address),
      .i_WriteData (i_WriteData),
      .i_WriteReg  (i_WriteReg),
      .o_ReadData  (o_ReadData),
      .o_WbValid   (o_WbValid),
      .o_WbReg     (o_WbReg),
      .o_Fault     (o_Fault),
      .o_MemReq    (o_MemReq),
      .i_MemAck    (i_MemAck),
      .o_MemWe     (o_MemWe),
      .o_MemAddr   (o_MemAddr),
      .o_MemWdata  (o_MemWdata),
      .o_MemBe     (o_MemBe),
      .i_MemRdata  (i_MemRdata)
   );

   initial r_Clock = 1'b0;
   always #5 r_Clock = ~r_Clock;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge r_Clock);
      #1;
   endtask

   // Reference model: plain arithmetic on access size in bytes.
   function automatic longint unsigned mSize(input logic [2:0] f3);
      longint unsigned one = 1;
      return one << f3[1:0];
   endfunction

   function automatic bit mLegal(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [63:0] a);
      if (rd && wr) return 1'b0;
      if (rd && f3 == 3'd7) return 1'b0;
      if (wr && f3 > 3'd3) return 1'b0;
      return (a % mSize(f3)) == 0;
   endfunction

   function automatic logic [7:0] mBe(input bit wr, input logic [2:0] f3, input logic [63:0] a);
      longint unsigned one = 1;
      longint unsigned sz = mSize(f3);
      if (!wr || sz == 8) return 8'hFF;
      return 8'(((one << sz) - 1) << (a % 8));
   endfunction

   function automatic logic [63:0] mWdata(input logic [2:0] f3, input logic [63:0] wd);
      longint unsigned one = 1;
      longint unsigned sz = mSize(f3);
      longint unsigned chunk, res;
      if (sz == 8) return wd;
      chunk = wd % (one << (sz * 8));
      res = 0;
      for (int i = 0; i < 8 / int'(sz); i++) res += chunk << (sz * 8 * longint'(i));
      return res;
   endfunction

   function automatic logic [63:0] mLoad(input logic [2:0] f3, input logic [63:0] a,
                                         input logic [63:0] rdata);
      longint unsigned one = 1;
      longint unsigned bits = mSize(f3) * 8;
      longint unsigned val = rdata >> ((a % 8) * 8);
      if (bits < 64) begin
         val = val % (one << bits);
         if (f3[2] == 1'b0 && val >= (one << (bits - 1))) val = val - (one << bits);
      end
      return val;
   endfunction

   task automatic runTxn(input string name, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rdReg,
                         input logic [63:0] rdata, input int ackDelay, input bit expFault,
                         input logic [7:0] expBe, input logic [63:0] expWd,
                         input logic [63:0] expRead);
      chkb({name, ".ready_before"}, o_Ready, 1'b1);
      i_Valid = 1'b1; i_MemRead = rd; i_MemWrite = wr; i_Funct3 = f3;
      i_Address = addr; i_WriteData = wd; i_WriteReg = rdReg;
      tick();
      i_Valid = 1'b0;
      if (expFault) begin
         chkb({name, ".fault"}, o_Fault, 1'b1);
         chkb({name, ".fault_noreq"}, o_MemReq, 1'b0);
         chkb({name, ".fault_ready"}, o_Ready, 1'b1);
         tick();
         chkb({name, ".fault_pulse_end"}, o_Fault, 1'b0);
         chkb({name, ".fault_noreq2"}, o_MemReq, 1'b0);
         return;
      end
      chkb({name, ".req"}, o_MemReq, 1'b1);
      chkb({name, ".busy"}, o_Ready, 1'b0);
      chkb({name, ".we"}, o_MemWe, wr);
      chk({name, ".addr"}, o_MemAddr, addr - (addr % 8));
      chk({name, ".be"}, 64'(o_MemBe), 64'(expBe));
      if (wr) chk({name, ".wdata"}, o_MemWdata, expWd);
      for (int i = 0; i < ackDelay; i++) begin
         tick();
         chkb({name, ".req_hold"}, o_MemReq, 1'b1);
         chk({name, ".addr_hold"}, o_MemAddr, addr - (addr % 8));
      end
      i_MemAck = 1'b1; i_MemRdata = rdata;
      tick();
      i_MemAck = 1'b0; i_MemRdata = {$urandom, $urandom};
      chkb({name, ".req_drop"}, o_MemReq, 1'b0);
      chkb({name, ".nofault"}, o_Fault, 1'b0);
      if (wr) begin
         chkb({name, ".st_nowb"}, o_WbValid, 1'b0);
         chkb({name, ".st_idle"}, o_Ready, 1'b1);
      end else begin
         chkb({name, ".wbvalid"}, o_WbValid, rdReg != 5'd0);
         chkb({name, ".done_busy"}, o_Ready, 1'b0);
         if (rdReg != 5'd0) begin
            chk({name, ".rdata"}, o_ReadData, expRead);
            chk({name, ".wbreg"}, 64'(o_WbReg), 64'(rdReg));
         end
         tick();
         chkb({name, ".wb_pulse_end"}, o_WbValid, 1'b0);
         chkb({name, ".back_idle"}, o_Ready, 1'b1);
         if (rdReg != 5'd0) chk({name, ".rdata_hold"}, o_ReadData, expRead);
      end
   endtask

   typedef struct {
      string       name;
      bit          rd;
      bit          wr;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] wd;
      logic [4:0]  rdReg;
      logic [63:0] rdata;
      int          ackDelay;
      bit          expFault;
      logic [7:0]  expBe;
      logic [63:0] expWd;
      logic [63:0] expRead;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int n;
      bit rd, wr;
      logic [2:0] f3;
      logic [63:0] addr;
      int unsigned pick;

      vecs[0]  = '{"LB_sext",   1, 0, 3'd0, 64'h1005, 64'h0, 5'd5,  64'h0000_8000_0000_0000, 3, 0, 8'hFF, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
      vecs[1]  = '{"LBU_zext",  1, 0, 3'd4, 64'h1005, 64'h0, 5'd6,  64'h0000_8000_0000_0000, 3, 0, 8'hFF, 64'h0, 64'h0000_0000_0000_0080};
      vecs[2]  = '{"SH",        0, 1, 3'd1, 64'h2002, 64'h1234, 5'd0, 64'h0, 1, 0, 8'h0C, 64'h1234_1234_1234_1234, 64'h0};
      vecs[3]  = '{"LW_misal",  1, 0, 3'd2, 64'h3002, 64'h0, 5'd7,  64'h0, 0, 1, 8'h00, 64'h0, 64'h0};
      vecs[4]  = '{"LD",        1, 0, 3'd3, 64'h4008, 64'h0, 5'd31, 64'h0123_4567_89AB_CDEF, 0, 0, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF};
      vecs[5]  = '{"LH_sext",   1, 0, 3'd1, 64'h5006, 64'h0, 5'd8,  64'hBEEF_0000_0000_0000, 2, 0, 8'hFF, 64'h0, 64'hFFFF_FFFF_FFFF_BEEF};
      vecs[6]  = '{"LWU",       1, 0, 3'd6, 64'h6004, 64'h0, 5'd9,  64'h89AB_CDEF_0000_0000, 1, 0, 8'hFF, 64'h0, 64'h0000_0000_89AB_CDEF};
      vecs[7]  = '{"LW_sext",   1, 0, 3'd2, 64'h6004, 64'h0, 5'd10, 64'h89AB_CDEF_0000_0000, 0, 0, 8'hFF, 64'h0, 64'hFFFF_FFFF_89AB_CDEF};
      vecs[8]  = '{"SB",        0, 1, 3'd0, 64'h7003, 64'h55AA, 5'd0, 64'h0, 2, 0, 8'h08, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0};
      vecs[9]  = '{"SD",        0, 1, 3'd3, 64'h8000, 64'h1122_3344_5566_7788, 5'd0, 64'h0, 0, 0, 8'hFF, 64'h1122_3344_5566_7788, 64'h0};
      vecs[10] = '{"LD_rd0",    1, 0, 3'd3, 64'h9000, 64'h0, 5'd0,  64'hDEAD_BEEF_DEAD_BEEF, 1, 0, 8'hFF, 64'h0, 64'h0};
      vecs[11] = '{"RW_both",   1, 1, 3'd3, 64'h9000, 64'h0, 5'd3,  64'h0, 0, 1, 8'h00, 64'h0, 64'h0};
      vecs[12] = '{"S_f3_4",    0, 1, 3'd4, 64'h9000, 64'h0, 5'd0,  64'h0, 0, 1, 8'h00, 64'h0, 64'h0};
      vecs[13] = '{"L_f3_7",    1, 0, 3'd7, 64'h9000, 64'h0, 5'd3,  64'h0, 0, 1, 8'h00, 64'h0, 64'h0};
      vecs[14] = '{"LHU_misal", 1, 0, 3'd5, 64'hA001, 64'h0, 5'd3,  64'h0, 0, 1, 8'h00, 64'h0, 64'h0};
      vecs[15] = '{"SW_hi",     0, 1, 3'd2, 64'hB004, 64'hDEAD_BEEF, 5'd0, 64'h0, 0, 0, 8'hF0, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0};

      i_Reset = 1'b1; i_Valid = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0; i_MemAck = 1'b0;
      i_Funct3 = '0; i_Address = '0; i_WriteData = '0; i_WriteReg = '0; i_MemRdata = '0;
      tick(); tick();
      chkb("rst.ready", o_Ready, 1'b1);
      chkb("rst.req", o_MemReq, 1'b0);
      chkb("rst.wbvalid", o_WbValid, 1'b0);
      chkb("rst.fault", o_Fault, 1'b0);
      chk("rst.rdata", o_ReadData, 64'h0);
      chk("rst.wbreg", 64'(o_WbReg), 64'h0);
      chk("rst.addr", o_MemAddr, 64'h0);
      chk("rst.wdata", o_MemWdata, 64'h0);
      chk("rst.be", 64'(o_MemBe), 64'h0);
      i_Reset = 1'b0;
      tick();

      foreach (vecs[k])
         runTxn(vecs[k].name, vecs[k].rd, vecs[k].wr, vecs[k].f3, vecs[k].addr, vecs[k].wd,
                vecs[k].rdReg, vecs[k].rdata, vecs[k].ackDelay, vecs[k].expFault,
                vecs[k].expBe, vecs[k].expWd, vecs[k].expRead);

      // Valid with neither read nor write: nothing happens.
      i_Valid = 1'b1; i_MemRead = 1'b0; i_MemWrite = 1'b0;
      tick();
      i_Valid = 1'b0;
      chkb("ignore.ready", o_Ready, 1'b1);
      chkb("ignore.req", o_MemReq, 1'b0);
      chkb("ignore.fault", o_Fault, 1'b0);

      // Timeout: LD never acknowledged, then a late ack must be ignored.
      i_Valid = 1'b1; i_MemRead = 1'b1; i_MemWrite = 1'b0; i_Funct3 = 3'd3;
      i_Address = 64'hC000; i_WriteReg = 5'd12;
      tick();
      i_Valid = 1'b0;
      n = 0;
      while (o_MemReq && n < 1000) begin
         n++;
         tick();
      end
      chk("timeout.req_cycles", 64'(n), 64'(c_TO));
      chkb("timeout.fault", o_Fault, 1'b1);
      chkb("timeout.req_low", o_MemReq, 1'b0);
      chkb("timeout.idle", o_Ready, 1'b1);
      chkb("timeout.nowb", o_WbValid, 1'b0);
      i_MemAck = 1'b1; i_MemRdata = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      i_MemAck = 1'b0;
      chkb("lateack.fault", o_Fault, 1'b0);
      chkb("lateack.nowb", o_WbValid, 1'b0);
      chkb("lateack.req", o_MemReq, 1'b0);
      chkb("lateack.ready", o_Ready, 1'b1);
      tick();
      chkb("lateack.nowb2", o_WbValid, 1'b0);

      // Reset while a load is pending on the bus.
      i_Valid = 1'b1; i_MemRead = 1'b1; i_Funct3 = 3'd3; i_Address = 64'hD000; i_WriteReg = 5'd4;
      tick();
      i_Valid = 1'b0;
      chkb("rstbus.req_on", o_MemReq, 1'b1);
      tick();
      i_Reset = 1'b1;
      tick();
      i_Reset = 1'b0;
      chkb("rstbus.req", o_MemReq, 1'b0);
      chkb("rstbus.ready", o_Ready, 1'b1);
      chkb("rstbus.nowb", o_WbValid, 1'b0);
      chkb("rstbus.nofault", o_Fault, 1'b0);
      chk("rstbus.rdata", o_ReadData, 64'h0);
      tick();
      chkb("rstbus.nowb2", o_WbValid, 1'b0);
      chkb("rstbus.nofault2", o_Fault, 1'b0);

      for (int t = 0; t < 150; t++) begin
         logic [63:0] wd, rdata;
         logic [4:0] rdReg;
         pick = $urandom_range(0, 19);
         rd = (pick < 10) || (pick == 19);
         wr = (pick >= 10);
         f3 = 3'($urandom_range(0, 7));
         addr = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) addr = addr - (addr % mSize(f3));
         wd = {$urandom, $urandom};
         rdata = {$urandom, $urandom};
         rdReg = 5'($urandom_range(0, 31));
         runTxn($sformatf("rnd%0d", t), rd, wr, f3, addr, wd, rdReg, rdata,
                int'($urandom_range(0, 4)), !mLegal(rd, wr, f3, addr),
                mBe(wr, f3, addr), mWdata(f3, wd), mLoad(f3, addr, rdata));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter c_TIMEOUT, default 255: bus cycles to wait for i_MemAck before abandoning a transaction.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 i_Clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 i_Reset  in  1  synchronous, active-high reset.
REQ-005 i_Valid  in  1  execute-stage request valid.
REQ-006 o_Ready  out  1  LSU can accept a request.
REQ-007 i_MemRead / i_MemWrite  in  1 each  load / store request.
REQ-008 i_Funct3  in  3  access size and signedness, using RV64 load/store encoding.
REQ-009 i_Address  in  64  effective address (ALU result).
REQ-010 i_WriteData  in  64  store data (rs2 register-file read port 2).
REQ-011 i_WriteReg  in  5  load destination rd.
REQ-012 o_ReadData  out  64  extended load data, feeds the register-file i_ReadData input.
REQ-013 o_WbValid  out  1  one-cycle pulse: o_ReadData and o_WbReg are valid.
REQ-014 o_WbReg  out  5  rd of the completing load.
REQ-015 o_Fault  out  1  one-cycle pulse: request rejected or timed out.
REQ-016 Memory bus:
- o_MemReq  out  1
- i_MemAck  in  1
- o_MemWe  out  1
- o_MemAddr  out  64, doubleword aligned
- o_MemWdata  out  64
- o_MemBe  out  8
- i_MemRdata  in  64

Function
REQ-017 The FSM SHALL have states IDLE, BUS and DONE; o_Ready SHALL be high only in IDLE.
REQ-018 A request is accepted when i_Valid & o_Ready are high; when i_MemRead and i_MemWrite are both low, the LSU SHALL ignore the request.
REQ-019 The LSU SHALL reject an accepted request with an o_Fault pulse in the next cycle, no bus activity and no state change, in each of these cases:
- i_MemRead & i_MemWrite both high
- load i_Funct3 = 111
- store i_Funct3[2] = 1
- address misaligned for the access size (H: addr[0] set; W: addr[1:0] nonzero; D: addr[2:0] nonzero)
REQ-020 A legal request SHALL register its inputs and move IDLE->BUS, with o_MemReq high from the next cycle and held with stable outputs until i_MemAck.
REQ-021 o_MemAddr SHALL equal {addr[63:3],3'b000}; o_MemWe = store.
REQ-022 o_MemBe for a store SHALL be:
- SB: 8'h01<<addr[2:0]
- SH: 8'h03<<addr[2:0]
- SW: 8'h0F<<addr[2:0]
- SD: 8'hFF
For a load, o_MemBe SHALL be 8'hFF.
REQ-023 o_MemWdata SHALL replicate the low byte, half or word of the store data across all lanes; SD passes i_WriteData unchanged.
REQ-024 On i_MemAck for a store, the FSM SHALL return BUS->IDLE with o_MemReq low next cycle and no o_WbValid.
REQ-025 On i_MemAck for a load, the LSU SHALL capture i_MemRdata>>(addr[2:0]*8), sign-extend it (LB/LH/LW) or zero-extend it (LBU/LHU/LWU; LD unchanged) into o_ReadData, and go BUS->DONE.
REQ-026 DONE SHALL last one cycle with o_WbValid=1 and o_WbReg=rd, then go to IDLE; load-to-writeback latency is the ack cycle plus 1.
REQ-027 A load with rd=0 SHALL perform the bus read but suppress o_WbValid.
REQ-028 A BUS cycle counter SHALL count from 0; if it reaches c_TIMEOUT without i_MemAck, the LSU SHALL pulse o_Fault, drop o_MemReq and go to IDLE.
REQ-029 A late i_MemAck arriving while in IDLE SHALL be ignored.
REQ-030 o_ReadData SHALL hold its last value outside DONE.

Reset
REQ-031 While i_Reset is high at a clock edge, the LSU SHALL set:
- state to IDLE
- o_MemReq, o_WbValid and o_Fault to 0
- o_ReadData to 0, o_WbReg to 0
- o_MemAddr, o_MemWdata and o_MemBe to 0
- timeout counter to 0
REQ-032 Reset during BUS or DONE SHALL abort the transaction with no writeback and no fault pulse.

Structure
REQ-033 Funct3 load/store encodings, FSM state encodings and c_TIMEOUT default SHALL live in the shared core definitions include.
REQ-034 Lane extraction, extension, byte-enable and replication logic SHALL be one combinational sub-module, lsu_align.

Verification
REQ-035 LB, addr 0x1005, ack after 3 cycles, rdata 0x0000_8000_0000_0000 -> o_ReadData 0xFFFF_FFFF_FFFF_FF80 (byte 0x80, sign-extended), o_WbValid one cycle after ack.
REQ-036 LBU, same stimulus -> o_ReadData 0x0000_0000_0000_0080.
REQ-037 SH, addr 0x2002, data 0x1234 -> o_MemBe 8'h0C, o_MemWdata 0x1234123412341234, o_MemAddr 0x2000, no o_WbValid.
REQ-038 LW at addr 0x3002 -> o_Fault pulse, o_MemReq never asserted, o_Ready stays 1.
REQ-039 LD, no ack for 255 cycles -> o_Fault pulse, o_MemReq low, back in IDLE; a later ack is ignored.
REQ-040 Reset asserted in BUS with a load pending -> o_MemReq 0 and o_Ready 1 the next cycle, with no o_WbValid and no o_Fault.
